// File: rtl/traffic_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_pkg
//  Description : Shared types and constants for the intersection controller:
//                FSM state encoding, interval selector codes, default
//                interval lengths.
//  Revision    : 1.0 - initial release
// ============================================================================
package traffic_pkg;

    // Controller states; the numeric codes are visible on the state output
    typedef enum logic [1:0] {
        GREEN_BASE = 2'd0,
        GREEN_EXT  = 2'd1,
        YELLOW     = 2'd2,
        WALK       = 2'd3
    } state_t;

    // Interval register selector codes
    localparam logic [1:0] SEL_BASE = 2'd0;
    localparam logic [1:0] SEL_EXT  = 2'd1;
    localparam logic [1:0] SEL_YEL  = 2'd2;
    localparam logic [1:0] SEL_WALK = 2'd3;

    // Interval register reset values, in seconds
    localparam int c_def_base = 6;
    localparam int c_def_ext  = 3;
    localparam int c_def_yel  = 2;
    localparam int c_def_walk = 3;

endpackage
`default_nettype wire

// File: rtl/phase_timer.sv
`default_nettype none
// ============================================================================
//  Module      : phase_timer
//  Description : Interval timer. A prescaler divides clk down to one tick per
//                second; a second counter runs from 0 and flags expiry in
//                the last cycle of a value-second interval. load restarts
//                both counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module phase_timer #(
    parameter int TIME_W   = 4,
    parameter int TICK_DIV = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic [TIME_W-1:0] value,
    output logic              expired
);

    logic              w_tick;
    logic [TIME_W-1:0] r_sec;

    generate
        if (TICK_DIV > 1) begin : g_prescaler
            localparam int c_pw = $clog2(TICK_DIV);
            localparam logic [c_pw-1:0] c_last = c_pw'(TICK_DIV - 1);
            logic [c_pw-1:0] r_presc;

            // Cycle-within-second counter, realigned on every load
            always_ff @(posedge clk or posedge reset) begin
                if (reset) begin
                    r_presc <= '0;
                end else if (load || w_tick) begin
                    r_presc <= '0;
                end else begin
                    r_presc <= r_presc + c_pw'(1);
                end
            end

            assign w_tick = (r_presc == c_last);
        end else begin : g_no_prescaler
            assign w_tick = 1'b1;
        end
    endgenerate

    // Elapsed-seconds counter for the running interval
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sec <= '0;
        end else if (load) begin
            r_sec <= '0;
        end else if (w_tick) begin
            r_sec <= r_sec + TIME_W'(1);
        end
    end

    // Last cycle of the last second of the interval
    assign expired = w_tick && (r_sec == value - TIME_W'(1));

endmodule
`default_nettype wire

// File: rtl/traffic_phase_controller.sv
`default_nettype none
// ============================================================================
//  Module      : traffic_phase_controller
//  Description : N-approach round-robin traffic-light controller with
//                demand skipping, green extension, end-of-cycle pedestrian
//                walk interval and runtime-programmable interval lengths.
//  Revision    : 1.0 - initial release
// ============================================================================
module traffic_phase_controller
    import traffic_pkg::*;
#(
    parameter int                NUM_PHASES = 3,
    parameter int                TIME_W     = 4,
    parameter int                TICK_DIV   = 1,
    parameter logic [TIME_W-1:0] DEF_BASE   = TIME_W'(c_def_base),
    parameter logic [TIME_W-1:0] DEF_EXT    = TIME_W'(c_def_ext),
    parameter logic [TIME_W-1:0] DEF_YEL    = TIME_W'(c_def_yel),
    parameter logic [TIME_W-1:0] DEF_WALK   = TIME_W'(c_def_walk)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_PHASES-1:0] sensor,
    input  logic                  walk_request,
    input  logic                  reprogram,
    input  logic [1:0]            time_parameter_selector,
    input  logic [TIME_W-1:0]     time_value,
    output logic [NUM_PHASES-1:0] red,
    output logic [NUM_PHASES-1:0] yellow,
    output logic [NUM_PHASES-1:0] green,
    output logic                  walk_light,
    output logic [1:0]            phase,
    output logic [1:0]            state,
    output logic                  expired
);

    logic [NUM_PHASES-1:0] r_sensor_meta, r_sensor_sync;
    logic                  r_walk_meta, r_walk_sync;
    logic                  r_prog_meta, r_prog_sync, r_prog_dly;
    logic                  w_prog_pulse;

    logic [TIME_W-1:0]     r_int_base, r_int_ext, r_int_yel, r_int_walk;
    logic [TIME_W-1:0]     w_interval;

    state_t                r_state, w_state_nxt;
    logic [1:0]            r_phase, w_phase_nxt;
    logic                  r_walk_pend;
    logic                  w_expired;

    logic                  w_sensor_cur;
    logic                  w_side_demand;
    logic [1:0]            w_next_phase;
    logic                  w_restart;

    // Two-flop synchronisers, plus one extra stage on reprogram for edge detect
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sensor_meta <= '0;
            r_sensor_sync <= '0;
            r_walk_meta   <= 1'b0;
            r_walk_sync   <= 1'b0;
            r_prog_meta   <= 1'b0;
            r_prog_sync   <= 1'b0;
            r_prog_dly    <= 1'b0;
        end else begin
            r_sensor_meta <= sensor;
            r_sensor_sync <= r_sensor_meta;
            r_walk_meta   <= walk_request;
            r_walk_sync   <= r_walk_meta;
            r_prog_meta   <= reprogram;
            r_prog_sync   <= r_prog_meta;
            r_prog_dly    <= r_prog_sync;
        end
    end

    assign w_prog_pulse = r_prog_sync & ~r_prog_dly;

    // Interval registers; a zero write is discarded so no interval can be empty
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_int_base <= DEF_BASE;
            r_int_ext  <= DEF_EXT;
            r_int_yel  <= DEF_YEL;
            r_int_walk <= DEF_WALK;
        end else if (w_prog_pulse && (time_value != '0)) begin
            case (time_parameter_selector)
                SEL_BASE: r_int_base <= time_value;
                SEL_EXT:  r_int_ext  <= time_value;
                SEL_YEL:  r_int_yel  <= time_value;
                default:  r_int_walk <= time_value;
            endcase
        end
    end

    // Interval length of the state currently being timed
    always_comb begin
        w_interval = r_int_base;
        case (r_state)
            GREEN_BASE: w_interval = r_int_base;
            GREEN_EXT:  w_interval = r_int_ext;
            YELLOW:     w_interval = r_int_yel;
            WALK:       w_interval = r_int_walk;
        endcase
    end

    // Every expiry enters a state (possibly the same one), so it always reloads
    phase_timer #(
        .TIME_W   (TIME_W),
        .TICK_DIV (TICK_DIV)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .load    (w_expired | w_prog_pulse),
        .value   (w_interval),
        .expired (w_expired)
    );

    // Demand summary: own-approach sensor, any side street, next served phase
    always_comb begin
        w_sensor_cur  = 1'b0;
        w_side_demand = 1'b0;
        w_next_phase  = 2'd0;
        for (int k = 0; k < NUM_PHASES; k++) begin
            if (r_phase == 2'(k)) begin
                w_sensor_cur = r_sensor_sync[k];
            end
            if (k >= 1) begin
                w_side_demand = w_side_demand | r_sensor_sync[k];
            end
        end
        // Descending scan so the lowest qualifying approach wins
        for (int k = NUM_PHASES - 1; k >= 1; k--) begin
            if ((2'(k) > r_phase) && r_sensor_sync[k]) begin
                w_next_phase = 2'(k);
            end
        end
    end

    // Main street keeps green when nobody else is waiting
    assign w_restart = (r_phase == 2'd0) && !w_side_demand && !r_walk_pend;

    // Next-state logic; reprogram overrides everything and restarts the cycle
    always_comb begin
        w_state_nxt = r_state;
        w_phase_nxt = r_phase;
        if (w_prog_pulse) begin
            w_state_nxt = GREEN_BASE;
            w_phase_nxt = 2'd0;
        end else if (w_expired) begin
            case (r_state)
                GREEN_BASE: begin
                    if (w_sensor_cur) begin
                        w_state_nxt = GREEN_EXT;
                    end else if (w_restart) begin
                        w_state_nxt = GREEN_BASE;
                        w_phase_nxt = 2'd0;
                    end else begin
                        w_state_nxt = YELLOW;
                    end
                end
                GREEN_EXT: begin
                    if (w_restart) begin
                        w_state_nxt = GREEN_BASE;
                        w_phase_nxt = 2'd0;
                    end else begin
                        w_state_nxt = YELLOW;
                    end
                end
                YELLOW: begin
                    if ((w_next_phase == 2'd0) && r_walk_pend) begin
                        w_state_nxt = WALK;
                    end else begin
                        w_state_nxt = GREEN_BASE;
                        w_phase_nxt = w_next_phase;
                    end
                end
                WALK: begin
                    w_state_nxt = GREEN_BASE;
                    w_phase_nxt = 2'd0;
                end
            endcase
        end
    end

    // State and phase registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= GREEN_BASE;
            r_phase <= 2'd0;
        end else begin
            r_state <= w_state_nxt;
            r_phase <= w_phase_nxt;
        end
    end

    // Pedestrian latch; a request seen on the WALK entry cycle is not lost
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_walk_pend <= 1'b0;
        end else if (r_walk_sync) begin
            r_walk_pend <= 1'b1;
        end else if ((w_state_nxt == WALK) && (r_state != WALK)) begin
            r_walk_pend <= 1'b0;
        end
    end

    // Lamp decode from registered state and phase only
    always_comb begin
        red        = '1;
        yellow     = '0;
        green      = '0;
        walk_light = (r_state == WALK);
        for (int k = 0; k < NUM_PHASES; k++) begin
            if (r_phase == 2'(k)) begin
                case (r_state)
                    GREEN_BASE, GREEN_EXT: begin
                        green[k] = 1'b1;
                        red[k]   = 1'b0;
                    end
                    YELLOW: begin
                        yellow[k] = 1'b1;
                        red[k]    = 1'b0;
                    end
                    default: ;
                endcase
            end
        end
    end

    assign phase   = r_phase;
    assign state   = r_state;
    assign expired = w_expired;

endmodule
`default_nettype wire

// File: tb/tb_traffic_phase_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_traffic_phase_controller
//  Description : Self-checking bench for traffic_phase_controller with a
//                behavioural countdown model of the intersection.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_traffic_phase_controller;

    localparam int NP = 3;
    localparam int TD = 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NP-1:0] sensor = '0;
    logic          walk_request = 1'b0;
    logic          reprogram = 1'b0;
    logic [1:0]    sel = 2'd0;
    logic [3:0]    tv = 4'd0;
    logic [NP-1:0] red, yellow, green;
    logic          walk_light;
    logic [1:0]    phase, state;
    logic          expired;
    logic [14:0]   obs;

    int checks = 0;
    int errors = 0;

    localparam logic [14:0] c_reset_vec = {3'b110, 3'b000, 3'b001, 1'b0, 2'd0, 2'd0, 1'b0};

    traffic_phase_controller #(
        .NUM_PHASES (NP),
        .TIME_W     (4),
        .TICK_DIV   (TD)
    ) dut (
        .clk                     (clk),
        .reset                   (reset),
        .sensor                  (sensor),
        .walk_request            (walk_request),
        .reprogram               (reprogram),
        .time_parameter_selector (sel),
        .time_value              (tv),
        .red                     (red),
        .yellow                  (yellow),
        .green                   (green),
        .walk_light              (walk_light),
        .phase                   (phase),
        .state                   (state),
        .expired                 (expired)
    );

    always #5 clk = ~clk;

    assign obs = {red, yellow, green, walk_light, phase, state, expired};

    // ---------------- reference model ----------------
    logic [1:0]    m_state, m_phase;
    int            m_rem;            // cycles left in current state, incl. this one
    int            m_iv[4];          // base, ext, yellow, walk seconds
    bit            m_walkp;
    logic [NP-1:0] sd1, sd2;         // raw sensor one and two edges ago
    bit            wd1, wd2, pd1, pd2, pd3;

    task automatic model_reset();
        m_state = 2'd0; m_phase = 2'd0;
        m_iv[0] = 6; m_iv[1] = 3; m_iv[2] = 2; m_iv[3] = 3;
        m_rem = m_iv[0] * TD;
        m_walkp = 1'b0;
        sd1 = '0; sd2 = '0; wd1 = 1'b0; wd2 = 1'b0;
        pd1 = 1'b0; pd2 = 1'b0; pd3 = 1'b0;
    endtask

    task automatic model_update();
        bit         pulse, entered, restart;
        logic [1:0] ns, np, nxt;
        pulse   = pd2 && !pd3;
        ns      = m_state;
        np      = m_phase;
        entered = 1'b0;
        restart = (m_phase == 2'd0) && (sd2[NP-1:1] == '0) && !m_walkp;
        if (pulse) begin
            if (tv != 4'd0) m_iv[sel] = int'(tv);
            ns = 2'd0; np = 2'd0; entered = 1'b1;
        end else if (m_rem == 1) begin
            entered = 1'b1;
            if (m_state == 2'd3) begin
                ns = 2'd0; np = 2'd0;
            end else if (m_state == 2'd2) begin
                nxt = 2'd0;
                for (int k = NP - 1; k > int'(m_phase); k--)
                    if (sd2[k]) nxt = 2'(k);
                if (nxt == 2'd0 && m_walkp) ns = 2'd3;
                else begin ns = 2'd0; np = nxt; end
            end else if (m_state == 2'd0 && sd2[m_phase]) begin
                ns = 2'd1;
            end else if (restart) begin
                ns = 2'd0; np = 2'd0;
            end else begin
                ns = 2'd2;
            end
        end
        if (wd2) m_walkp = 1'b1;
        else if (ns == 2'd3 && m_state != 2'd3) m_walkp = 1'b0;
        m_rem   = entered ? m_iv[ns] * TD : m_rem - 1;
        m_state = ns;
        m_phase = np;
        pd3 = pd2; pd2 = pd1; pd1 = reprogram;
        sd2 = sd1; sd1 = sensor;
        wd2 = wd1; wd1 = walk_request;
    endtask

    function automatic logic [14:0] exp_vec();
        logic [NP-1:0] g, y, r;
        logic          wl;
        g = '0; y = '0; r = '1; wl = 1'b0;
        if (m_state == 2'd0 || m_state == 2'd1) begin
            g[m_phase] = 1'b1; r[m_phase] = 1'b0;
        end else if (m_state == 2'd2) begin
            y[m_phase] = 1'b1; r[m_phase] = 1'b0;
        end else begin
            wl = 1'b1;
        end
        return {r, y, g, wl, m_phase, m_state, (m_rem == 1)};
    endfunction

    // Advance one clock, keeping the model in step; returns on the falling edge
    task automatic tick();
        @(posedge clk);
        if (reset) model_reset();
        else model_update();
        @(negedge clk);
    endtask

    task automatic do_reset();
        reset = 1'b1; sensor = '0; walk_request = 1'b0; reprogram = 1'b0;
        sel = 2'd0; tv = 4'd0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        do_reset();
        checks++;
        if (obs !== c_reset_vec) begin
            errors++;
            $display("FAIL reset_outputs got %h want %h", obs, c_reset_vec);
        end
        checks++;
        if (obs !== exp_vec()) begin
            errors++;
            $display("FAIL reset_model got %h want %h", obs, exp_vec());
        end
    endtask

    task automatic test_idle();
        int last;
        do_reset();
        last = -1;
        for (int c = 0; c < 40; c++) begin
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL idle_model c=%0d got %h want %h", c, obs, exp_vec());
            end
            checks++;
            if (green[0] !== 1'b1 || yellow !== '0) begin
                errors++;
                $display("FAIL idle_lamps c=%0d green %b yellow %b want green0=1 yellow=000", c, green, yellow);
            end
            if (expired) begin
                if (last >= 0) begin
                    checks++;
                    if (c - last != 6) begin
                        errors++;
                        $display("FAIL idle_period got %0d want 6", c - last);
                    end
                end
                last = c;
            end
            tick();
        end
        checks++;
        if (last != 35) begin
            errors++;
            $display("FAIL idle_last_expiry got %0d want 35", last);
        end
    endtask

    task automatic test_side_demand();
        int            seg_len[5] = '{6, 2, 9, 2, 6};
        int            seg_ph[5]  = '{0, 0, 1, 1, 0};
        bit            seg_grn[5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [NP-1:0] eg, ey;
        int            c;
        do_reset();
        sensor = 3'b010;
        c = 0;
        for (int s = 0; s < 5; s++) begin
            for (int i = 0; i < seg_len[s]; i++) begin
                eg = '0; ey = '0;
                if (seg_grn[s]) eg[seg_ph[s]] = 1'b1;
                else ey[seg_ph[s]] = 1'b1;
                checks++;
                if ({yellow, green} !== {ey, eg}) begin
                    errors++;
                    $display("FAIL side_lamps c=%0d got y%b g%b want y%b g%b", c, yellow, green, ey, eg);
                end
                checks++;
                if (obs !== exp_vec()) begin
                    errors++;
                    $display("FAIL side_model c=%0d got %h want %h", c, obs, exp_vec());
                end
                tick();
                c++;
            end
        end
    endtask

    task automatic test_walk();
        logic [3*NP:0] want;   // {red, yellow, green, walk_light}
        do_reset();
        for (int c = 0; c < 23; c++) begin
            if (c <= 5 || c >= 11) want = {3'b110, 3'b000, 3'b001, 1'b0};
            else if (c <= 7)       want = {3'b110, 3'b001, 3'b000, 1'b0};
            else                   want = {3'b111, 3'b000, 3'b000, 1'b1};
            checks++;
            if ({red, yellow, green, walk_light} !== want) begin
                errors++;
                $display("FAIL walk_lamps c=%0d got %b want %b", c, {red, yellow, green, walk_light}, want);
            end
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL walk_model c=%0d got %h want %h", c, obs, exp_vec());
            end
            walk_request = (c == 1);
            tick();
        end
    endtask

    task automatic test_reprogram();
        int first_exp, run, nruns;
        do_reset();
        sel = 2'd2; tv = 4'd5;
        first_exp = -1;
        for (int c = 0; c < 12; c++) begin
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL reprog_model c=%0d got %h want %h", c, obs, exp_vec());
            end
            if (expired && first_exp < 0) first_exp = c;
            reprogram = (c >= 2);
            tick();
        end
        checks++;
        if (first_exp != 10) begin
            errors++;
            $display("FAIL reprog_restart first expiry at %0d want 10", first_exp);
        end
        sensor = 3'b010;
        run = 0; nruns = 0;
        for (int c = 0; c < 60; c++) begin
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL reprog_model2 c=%0d got %h want %h", c, obs, exp_vec());
            end
            if (|yellow) run++;
            else if (run > 0) begin
                checks++;
                if (run != 5) begin
                    errors++;
                    $display("FAIL reprog_yellow_len got %0d want 5", run);
                end
                nruns++; run = 0;
            end
            tick();
        end
        checks++;
        if (nruns < 2) begin
            errors++;
            $display("FAIL reprog_yellow_runs got %0d want >=2", nruns);
        end
        // Zero write must leave the yellow interval at 5
        reprogram = 1'b0;
        for (int c = 0; c < 4; c++) tick();
        tv = 4'd0; reprogram = 1'b1;
        run = 0; nruns = 0;
        for (int c = 0; c < 40; c++) begin
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL reprog_zero_model c=%0d got %h want %h", c, obs, exp_vec());
            end
            if (|yellow) run++;
            else if (run > 0) begin
                checks++;
                if (run != 5) begin
                    errors++;
                    $display("FAIL reprog_zero_yellow_len got %0d want 5", run);
                end
                nruns++; run = 0;
            end
            tick();
        end
        checks++;
        if (nruns < 1) begin
            errors++;
            $display("FAIL reprog_zero_runs got %0d want >=1", nruns);
        end
    endtask

    // Continues from the reprogrammed state left by test_reprogram
    task automatic test_async_reset();
        bit            found;
        int            seg_len[4] = '{6, 2, 9, 2};
        int            seg_ph[4]  = '{0, 0, 1, 1};
        bit            seg_grn[4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        logic [NP-1:0] eg, ey;
        sensor = 3'b010;
        found = 1'b0;
        for (int c = 0; c < 60 && !found; c++) begin
            if (state == 2'd2 && phase == 2'd1) found = 1'b1;
            else tick();
        end
        checks++;
        if (!found) begin
            errors++;
            $display("FAIL async_reach_yellow got state %0d phase %0d want 2 1", state, phase);
        end
        #2;
        reset = 1'b1;
        model_reset();
        #1;
        checks++;
        if (obs !== c_reset_vec) begin
            errors++;
            $display("FAIL async_reset_outputs got %h want %h", obs, c_reset_vec);
        end
        @(negedge clk);
        reset = 1'b0; reprogram = 1'b0; tv = 4'd0; sensor = 3'b010;
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < seg_len[s]; i++) begin
                eg = '0; ey = '0;
                if (seg_grn[s]) eg[seg_ph[s]] = 1'b1;
                else ey[seg_ph[s]] = 1'b1;
                checks++;
                if ({yellow, green} !== {ey, eg}) begin
                    errors++;
                    $display("FAIL async_defaults_lamps got y%b g%b want y%b g%b", yellow, green, ey, eg);
                end
                tick();
            end
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        for (int c = 0; c < 23; c++) begin
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL simul_model c=%0d got %h want %h", c, obs, exp_vec());
            end
            if (c == 8 || c == 19) begin
                checks++;
                if (state !== 2'd3 || walk_light !== 1'b1) begin
                    errors++;
                    $display("FAIL simul_walk c=%0d got state %0d walk %b want 3 1", c, state, walk_light);
                end
            end
            walk_request = (c == 1 || c == 5);
            tick();
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            checks++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL random_model c=%0d got %h want %h", c, obs, exp_vec());
            end
            if ($urandom_range(0, 5) == 0) sensor = NP'($urandom);
            walk_request = ($urandom_range(0, 24) == 0);
            if ($urandom_range(0, 59) == 0) reprogram = ~reprogram;
            sel = 2'($urandom);
            tv  = 4'($urandom_range(0, 7));
            tick();
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_idle();
        test_side_demand();
        test_walk();
        test_reprogram();
        test_async_reset();
        test_simultaneous();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
